// File: rtl/timestamp_uart_rx.sv
// 8N1 receiver for the build-timestamp link; parses "XXXXXXXX\r" hex lines into a 32-bit value.
// Pulses are registered one enabled cycle after the stop sample; no backpressure, CK_EE_i gates all state.
module timestamp_uart_rx #(
    parameter int C_FCK       = 48_000_000,
    parameter int C_BAUD_RATE = 19_200
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic        CK_EE_i,
    input  logic        RXD_i,
    output logic [7:0]  RX_DATs_o,
    output logic        RX_STB_o,
    output logic [31:0] TIMESTAMPs_o,
    output logic        VALID_o,
    output logic        ERR_o
);
    localparam int C_DIV_LEN = C_FCK / C_BAUD_RATE;
    localparam int CW        = $clog2(C_DIV_LEN + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(C_DIV_LEN / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(C_DIV_LEN - 1);

    if (C_DIV_LEN < 4) begin : g_div_check
        $error("timestamp_uart_rx: C_FCK / C_BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t         state_q, state_d;
    logic [1:0]     sync_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic [7:0]     rx_dat_q, rx_dat_d;
    logic           rx_stb_q, rx_stb_d;
    logic [31:0]    ts_q, ts_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [31:0]    acc_q, acc_d;
    logic [3:0]     dcnt_q, dcnt_d;
    logic           bad_q, bad_d;
    logic           srxd, good_byte, is_dig, is_alpha;
    logic [3:0]     nib;

    assign srxd     = sync_q[1];
    assign is_dig   = (sh_q >= 8'h30) && (sh_q <= 8'h39);
    assign is_alpha = ((sh_q >= 8'h41) && (sh_q <= 8'h46)) || ((sh_q >= 8'h61) && (sh_q <= 8'h66));
    // Letters A-F/a-f have low nibble 1..6, so adding 9 gives 10..15.
    assign nib      = is_dig ? sh_q[3:0] : sh_q[3:0] + 4'd9;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rx_dat_d  = rx_dat_q;
        ts_d      = ts_q;
        acc_d     = acc_q;
        dcnt_d    = dcnt_q;
        bad_d     = bad_q;
        rx_stb_d  = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        good_byte = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!srxd) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (srxd) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = FULL_M1;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    sh_d  = {srxd, sh_q[7:1]};
                    cnt_d = FULL_M1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (srxd) begin
                    good_byte = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    bad_d   = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (srxd) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (good_byte) begin
            rx_dat_d = sh_q;
            rx_stb_d = 1'b1;
            if (is_dig || is_alpha) begin
                acc_d = {acc_q[27:0], nib};
                if (dcnt_q == 4'd8) bad_d  = 1'b1;
                else                dcnt_d = dcnt_q + 4'd1;
            end else if (sh_q == 8'h0D) begin
                if ((dcnt_q == 4'd8) && !bad_q) begin
                    ts_d    = acc_q;
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
                acc_d  = '0;
                dcnt_d = '0;
                bad_d  = 1'b0;
            end else if (sh_q != 8'h0A) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q  <= S_IDLE;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_dat_q <= '0;
            rx_stb_q <= 1'b0;
            ts_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            dcnt_q   <= '0;
            bad_q    <= 1'b0;
        end else if (CK_EE_i) begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], RXD_i};
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_dat_q <= rx_dat_d;
            rx_stb_q <= rx_stb_d;
            ts_q     <= ts_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            dcnt_q   <= dcnt_d;
            bad_q    <= bad_d;
        end
    end

    assign RX_DATs_o    = rx_dat_q;
    assign RX_STB_o     = rx_stb_q;
    assign TIMESTAMPs_o = ts_q;
    assign VALID_o      = valid_q;
    assign ERR_o        = err_q;
endmodule

// File: tb/tb_timestamp_uart_rx.sv
// Bench for timestamp_uart_rx: a UART line driver, a line-level reference model and a pulse scoreboard.
module tb_timestamp_uart_rx;
    localparam int DIV = 10_000 / 300;

    logic        CK_i = 1'b0;
    logic        XARST_i = 1'b1;
    logic        CK_EE_i = 1'b1;
    logic        RXD_i = 1'b1;
    logic [7:0]  RX_DATs_o;
    logic        RX_STB_o;
    logic [31:0] TIMESTAMPs_o;
    logic        VALID_o;
    logic        ERR_o;

    timestamp_uart_rx #(.C_FCK(10_000), .C_BAUD_RATE(300)) dut (
        .CK_i(CK_i), .XARST_i(XARST_i), .CK_EE_i(CK_EE_i), .RXD_i(RXD_i),
        .RX_DATs_o(RX_DATs_o), .RX_STB_o(RX_STB_o), .TIMESTAMPs_o(TIMESTAMPs_o),
        .VALID_o(VALID_o), .ERR_o(ERR_o)
    );

    always #5 CK_i = ~CK_i;

    int          tests = 0, failed = 0;
    int          got_err = 0, exp_err = 0, n_pulse = 0, n_valid = 0;
    bit          ce_toggle = 1'b0;
    bit          line_bad = 1'b0;
    logic [31:0] last_ts = '0;
    logic [7:0]  exp_rx[$];
    logic [31:0] exp_ts[$];
    logic [7:0]  lbuf[$];
    logic [7:0]  exp_b;
    logic [31:0] exp_w;

    // Scoreboard: each pulse is counted on the one negedge that precedes the enabled edge clearing it.
    always @(negedge CK_i) begin
        if (XARST_i && CK_EE_i) begin
            if (RX_STB_o || VALID_o || ERR_o) n_pulse++;
            if (RX_STB_o) begin
                tests++;
                if (exp_rx.size() == 0) begin
                    failed++;
                    $display("FAIL rx_byte: got %h, expected no strobe", RX_DATs_o);
                end else begin
                    exp_b = exp_rx.pop_front();
                    if (RX_DATs_o !== exp_b) begin
                        failed++;
                        $display("FAIL rx_byte: got %h, want %h", RX_DATs_o, exp_b);
                    end
                end
            end
            if (VALID_o) begin
                n_valid++;
                tests++;
                if (exp_ts.size() == 0) begin
                    failed++;
                    $display("FAIL valid_ts: got %h, expected no VALID_o", TIMESTAMPs_o);
                end else begin
                    exp_w = exp_ts.pop_front();
                    if (TIMESTAMPs_o !== exp_w) begin
                        failed++;
                        $display("FAIL valid_ts: got %h, want %h", TIMESTAMPs_o, exp_w);
                    end
                end
            end
            if (ERR_o) got_err++;
            if (VALID_o || ERR_o) begin
                tests++;
                if (VALID_o && ERR_o) begin
                    failed++;
                    $display("FAIL valid_err_excl: VALID_o=%b ERR_o=%b, want not both", VALID_o, ERR_o);
                end
            end
        end
    end

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    // A line is accepted only if it holds exactly eight hex characters and saw no framing error.
    function automatic void model_cr();
        logic [31:0] v = '0;
        bit ok = !line_bad && (lbuf.size() == 8);
        foreach (lbuf[i]) begin
            if (hexval(lbuf[i]) < 0) ok = 1'b0;
            else v = v * 16 + 32'(hexval(lbuf[i]));
        end
        if (ok) begin
            exp_ts.push_back(v);
            last_ts = v;
        end else begin
            exp_err++;
        end
        lbuf.delete();
        line_bad = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        exp_rx.push_back(b);
        if (b == 8'h0D)      model_cr();
        else if (b != 8'h0A) lbuf.push_back(b);
    endfunction

    task automatic tick();
        @(posedge CK_i);
        #1;
        CK_EE_i = ce_toggle ? ~CK_EE_i : 1'b1;
    endtask

    task automatic send_bit(input logic v);
        int n = 0;
        RXD_i = v;
        while (n < DIV) begin
            if (CK_EE_i) n++;
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        model_byte(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        repeat (gap) tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, 2));
    endtask

    task automatic send_frame_err(input logic [7:0] b);
        exp_err++;
        line_bad = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        repeat (4) send_bit(1'b0);
        RXD_i = 1'b1;
        repeat (2 * DIV) tick();
    endtask

    task automatic clear_counts();
        got_err = 0;
        exp_err = 0;
        n_pulse = 0;
        n_valid = 0;
    endtask

    task automatic drain();
        repeat (80) tick();
    endtask

    task automatic test_reset();
        #2 XARST_i = 1'b0;
        RXD_i = 1'b1;
        repeat (3) tick();
        tests++; if (RX_DATs_o !== 8'h00)     begin failed++; $display("FAIL rst_rx_dat: got %h, want 00", RX_DATs_o); end
        tests++; if (RX_STB_o !== 1'b0)       begin failed++; $display("FAIL rst_rx_stb: got %b, want 0", RX_STB_o); end
        tests++; if (TIMESTAMPs_o !== 32'h0)  begin failed++; $display("FAIL rst_ts: got %h, want 0", TIMESTAMPs_o); end
        tests++; if (VALID_o !== 1'b0)        begin failed++; $display("FAIL rst_valid: got %b, want 0", VALID_o); end
        tests++; if (ERR_o !== 1'b0)          begin failed++; $display("FAIL rst_err: got %b, want 0", ERR_o); end
        XARST_i = 1'b1;
        clear_counts();
        repeat (1000) tick();
        tests++; if (n_pulse != 0)            begin failed++; $display("FAIL rst_idle_pulses: got %0d, want 0", n_pulse); end
        tests++; if (TIMESTAMPs_o !== 32'h0)  begin failed++; $display("FAIL rst_idle_ts: got %h, want 0", TIMESTAMPs_o); end
    endtask

    task automatic test_basic_line();
        clear_counts();
        send_str("2024A1F5\r\n");
        drain();
        tests++; if (exp_rx.size() != 0)          begin failed++; $display("FAIL basic_rx_left: %0d bytes unstrobed, want 0", exp_rx.size()); end
        tests++; if (n_valid != 1)                begin failed++; $display("FAIL basic_valid_cnt: got %0d, want 1", n_valid); end
        tests++; if (TIMESTAMPs_o !== 32'h2024A1F5) begin failed++; $display("FAIL basic_ts: got %h, want 2024a1f5", TIMESTAMPs_o); end
        tests++; if (got_err != 0)                begin failed++; $display("FAIL basic_err: got %0d, want 0", got_err); end
    endtask

    task automatic test_bad_lines();
        clear_counts();
        send_str("deadbeef\r1234567\r12G45678\r");
        drain();
        tests++; if (exp_ts.size() != 0)            begin failed++; $display("FAIL bad_ts_left: %0d VALID_o missing, want 0", exp_ts.size()); end
        tests++; if (got_err != 2)                  begin failed++; $display("FAIL bad_err_cnt: got %0d, want 2", got_err); end
        tests++; if (TIMESTAMPs_o !== 32'hDEADBEEF) begin failed++; $display("FAIL bad_ts_hold: got %h, want deadbeef", TIMESTAMPs_o); end
    endtask

    task automatic test_framing();
        clear_counts();
        send_str("12");
        send_frame_err(8'h5A);
        send_str("345\r");
        send_str("0000FFFF\r");
        drain();
        tests++; if (got_err != exp_err)            begin failed++; $display("FAIL frame_err_cnt: got %0d, want %0d", got_err, exp_err); end
        tests++; if (n_valid != 1)                  begin failed++; $display("FAIL frame_valid_cnt: got %0d, want 1", n_valid); end
        tests++; if (TIMESTAMPs_o !== 32'h0000FFFF) begin failed++; $display("FAIL frame_ts: got %h, want 0000ffff", TIMESTAMPs_o); end
        tests++; if (exp_rx.size() != 0)            begin failed++; $display("FAIL frame_rx_left: %0d bytes unstrobed, want 0", exp_rx.size()); end
    endtask

    task automatic test_glitch();
        clear_counts();
        RXD_i = 1'b0;
        repeat (10) tick();
        RXD_i = 1'b1;
        repeat (3 * DIV) tick();
        tests++; if (n_pulse != 0) begin failed++; $display("FAIL glitch_pulses: got %0d, want 0", n_pulse); end
        send_str("CAFEF00D\r");
        drain();
        tests++; if (TIMESTAMPs_o !== 32'hCAFEF00D) begin failed++; $display("FAIL glitch_next_ts: got %h, want cafef00d", TIMESTAMPs_o); end
        tests++; if (got_err != 0) begin failed++; $display("FAIL glitch_err: got %0d, want 0", got_err); end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_str("AB");
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        XARST_i = 1'b0;
        repeat (3) tick();
        RXD_i = 1'b1;
        tick();
        XARST_i = 1'b1;
        lbuf.delete();
        line_bad = 1'b0;
        last_ts = '0;
        tests++; if (TIMESTAMPs_o !== 32'h0) begin failed++; $display("FAIL midrst_ts: got %h, want 0", TIMESTAMPs_o); end
        repeat (2 * DIV) tick();
        tests++; if (got_err != 0) begin failed++; $display("FAIL midrst_err: got %0d, want 0", got_err); end
        send_str("89abCDEF\r");
        drain();
        tests++; if (TIMESTAMPs_o !== 32'h89ABCDEF) begin failed++; $display("FAIL midrst_next_ts: got %h, want 89abcdef", TIMESTAMPs_o); end
        tests++; if (exp_ts.size() != 0) begin failed++; $display("FAIL midrst_ts_left: %0d VALID_o missing, want 0", exp_ts.size()); end
    endtask

    task automatic send_random_line();
        logic [31:0] v;
        logic [7:0]  c;
        int kind, ndig;
        v    = $urandom;
        kind = $urandom_range(0, 3);
        ndig = 8;
        if (kind == 1) ndig = $urandom_range(0, 1) ? 7 : 9;
        for (int i = ndig - 1; i >= 0; i--) begin
            c = hexchar(v[(i % 8) * 4 +: 4], 1'($urandom_range(0, 1)));
            if (kind == 2 && i == 3) c = $urandom_range(0, 1) ? 8'h47 : 8'h7A;
            send_byte(c, $urandom_range(0, 3));
        end
        send_byte(8'h0D, $urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) send_byte(8'h0A, 0);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        for (int l = 0; l < 4; l++) send_random_line();
        drain();
        tests++; if (exp_rx.size() != 0) begin failed++; $display("FAIL b2b_rx_left: %0d bytes unstrobed, want 0", exp_rx.size()); end
        tests++; if (exp_ts.size() != 0) begin failed++; $display("FAIL b2b_ts_left: %0d VALID_o missing, want 0", exp_ts.size()); end
        tests++; if (got_err != exp_err) begin failed++; $display("FAIL b2b_err_cnt: got %0d, want %0d", got_err, exp_err); end
        tests++; if (TIMESTAMPs_o !== last_ts) begin failed++; $display("FAIL b2b_ts: got %h, want %h", TIMESTAMPs_o, last_ts); end
    endtask

    task automatic test_clock_enable();
        logic [31:0] v;
        clear_counts();
        ce_toggle = 1'b1;
        for (int l = 0; l < 2; l++) begin
            v = $urandom;
            for (int i = 7; i >= 0; i--) send_byte(hexchar(v[i * 4 +: 4], 1'($urandom_range(0, 1))), 0);
            send_byte(8'h0D, 0);
            send_byte(8'h0A, $urandom_range(0, 4));
        end
        drain();
        ce_toggle = 1'b0;
        tick();
        tests++; if (n_valid != 2)             begin failed++; $display("FAIL ce_valid_cnt: got %0d, want 2", n_valid); end
        tests++; if (TIMESTAMPs_o !== last_ts) begin failed++; $display("FAIL ce_ts: got %h, want %h", TIMESTAMPs_o, last_ts); end
        tests++; if (got_err != 0)             begin failed++; $display("FAIL ce_err: got %0d, want 0", got_err); end
        tests++; if (exp_rx.size() != 0)       begin failed++; $display("FAIL ce_rx_left: %0d bytes unstrobed, want 0", exp_rx.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_bad_lines();
        test_framing();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_clock_enable();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/timestamp_uart_rx.md
# timestamp_uart_rx

Receive side of the build-timestamp serial link. Deserialises the 8N1 ASCII stream produced by the upstream timestamp transmitter, which sends eight uppercase hex digits MSB-first followed by CR LF. It parses each line back into a 32-bit value and presents it with a one-cycle valid strobe. It sits on the bench or on a second FPGA at the far end of the TXD wire, and is also used for loopback checking of the transmitter.

## Interface
- C_FCK, 48_000_000: clock frequency in Hz.
- C_BAUD_RATE, 19_200: line rate in bit/s.
- C_DIV_LEN = C_FCK / C_BAUD_RATE, integer division, derived: clocks per bit; must be ≥ 4.

- CK_i  in  1  clock.
- XARST_i  in  1  reset; one clock, reset asynchronous and active-low.
- CK_EE_i  in  1  clock enable; tri1, defaults high. All state advances only on CK_i edges with CK_EE_i=1.
- RXD_i  in  1  serial input; idle high; tri1.
- RX_DATs_o  out  8  last received byte.
- RX_STB_o  out  1  pulse: RX_DATs_o updated with a good frame.
- TIMESTAMPs_o  out  32  last accepted timestamp.
- VALID_o  out  1  pulse: TIMESTAMPs_o updated.
- ERR_o  out  1  pulse: framing error or rejected line.

## Operation
- Input sync: two flops, reset to 1. All logic uses the synchronised value SRXD.
- Rx FSM states:
  - IDLE: falling edge of SRXD → START, with the bit counter loaded to wait C_DIV_LEN/2 cycles.
  - START: at the half-bit sample point, SRXD=1 is a false start → IDLE, with no strobe and no error. SRXD=0 → DATA.
  - DATA: 8 samples taken every C_DIV_LEN cycles, LSB first, shifted into the data register → STOP.
  - STOP: after C_DIV_LEN cycles, sample SRXD.
    - SRXD=1 → good byte: RX_DATs_o/RX_STB_o updated, byte passed to the parser → IDLE.
    - SRXD=0 → framing error: ERR_o pulse, current line marked bad → BREAK_WAIT.
  - BREAK_WAIT: stays until SRXD=1 for one enabled cycle → IDLE.
- Line parser: holds a 32-bit shift accumulator, a 4-bit digit count (0..8) and a bad flag. The accumulator, digit count and bad flag all reset to 0.
  - '0'-'9', 'A'-'F', 'a'-'f': accumulator shifts left by 4 and the nibble is inserted. Digit count increments. A 9th digit sets bad; the count saturates at 8.
  - CR (8'h0D), with count==8 and not bad: TIMESTAMPs_o←accumulator and VALID_o pulse. Otherwise: ERR_o pulse, TIMESTAMPs_o unchanged. In either case the accumulator, count and bad flag clear.
  - LF (8'h0A): ignored, with no state change.
  - Any other byte: sets bad, with no immediate ERR_o; the error is reported at the next CR.
  - Framing error: sets bad and pulses ERR_o immediately. The following CR then pulses ERR_o again.
- Nibble conversion:
  - '0'-'9': byte−8'h30.
  - 'A'-'F': byte−8'h37.
  - 'a'-'f': byte−8'h57.

## Timing
- Reset values:
  - RX_DATs_o = 8'h00.
  - RX_STB_o = 0.
  - TIMESTAMPs_o = 32'h0.
  - VALID_o = 0.
  - ERR_o = 0.
  - FSM = IDLE.
  - Sync flops = 1.
- Reset mid-frame aborts the frame and the line with no pulse.
- Sample points, counted from the first enabled cycle with SRXD=0:
  - Start bit at +C_DIV_LEN/2.
  - Data bit n at +C_DIV_LEN/2 + (n+1)·C_DIV_LEN.
  - Stop bit at +C_DIV_LEN/2 + 9·C_DIV_LEN.
- RXD_i → SRXD latency: 2 cycles.
- RX_STB_o and ERR_o (framing) are high on the enabled cycle after the stop sample.
- VALID_o / ERR_o (line) for a CR are high in the same cycle as that CR's RX_STB_o.
- All pulses are registered. Each is high for exactly one enabled cycle and cleared at the next enabled cycle; with CK_EE_i=1 this is one CK_i cycle.
- VALID_o and ERR_o are never high together.
- Back-to-back frames are required: a falling edge seen in the cycle IDLE is entered must start a new frame.
- Baud mismatch tolerance: ±2% between transmitter and receiver.

## Test plan
All scenarios use C_FCK=10_000 and C_BAUD_RATE=300 (C_DIV_LEN=33) and drive frames from a bench UART model.
- Reset with RXD_i=1 → all outputs at their reset values; no pulse for 1000 cycles.
- Send "2024A1F5\r\n" → 10 RX_STB_o pulses, RX_DATs_o values matching the characters. One VALID_o with TIMESTAMPs_o=32'h2024A1F5; ERR_o never high.
- Send "deadbeef\r", then "1234567\r" (7 digits), then "12G45678\r" → first line gives VALID_o with 32'hDEADBEEF. Each of the other two gives one ERR_o, with TIMESTAMPs_o held at 32'hDEADBEEF.
- A frame with stop bit 0 in the middle of a line, then RXD_i held low for 3 bit times, then released, then "0000FFFF\r" → first line gives ERR_o (framing) plus ERR_o at its CR. The following line gives VALID_o with 32'h0000FFFF.
- RXD_i low for 10 cycles only (glitch) → no RX_STB_o, no ERR_o, FSM back to IDLE.
- Reset mid-frame, after 4 data bits → no pulse. The next full line decodes correctly.
- Loopback from the upstream transmitter with CK_EE_i toggled 1/0 on alternate cycles on both blocks → VALID_o recurs every line with TIMESTAMPs_o equal to the transmitter's timestamp.
